// File: rtl/occupancy_map_dumper.sv
// occupancy_map_dumper
//   Read-out engine for the occupancy grid RAM. A start pulse in IDLE walks
//   the map from address 0 to DEPTH-1 and streams each cell over a
//   valid/ready link, tagging the final cell with out_last. Read data lands
//   in a 2-entry FIFO whose head drives the output, so the stream runs at one
//   word per cycle under continuous ready and never overflows under backpressure.
//
// Ports
//   clock, reset           single clock, synchronous active-high reset
//   start                  one-cycle dump request, honoured only in IDLE
//   busy                   high while the block owns the RAM read port
//   done                   one-cycle pulse after the last word handshakes
//   mem_read_enable        RAM read strobe
//   mem_address            RAM read address
//   mem_read_data          RAM data, valid one cycle after the strobe
//   out_valid/out_ready    output handshake
//   out_data               cell value, ascending address order
//   out_last               marks the cell from address DEPTH-1
module occupancy_map_dumper #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 32768,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_read_enable,
  output logic [ADDR_WIDTH-1:0] mem_address,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);

  // One extra bit so the counters can hold DEPTH itself.
  localparam int CW = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t                  state;
  logic [CW-1:0]           issue_cnt;
  logic [CW-1:0]           sent_cnt;
  logic                    inflight;
  logic [DATA_WIDTH-1:0]   fifo_mem [2];
  logic                    wr_ptr;
  logic                    rd_ptr;
  logic [1:0]              count;

  logic                    pop;
  logic [2:0]              level;
  logic                    issue;
  logic                    last_hs;

  assign out_valid = (count != 2'd0);
  assign out_data  = fifo_mem[rd_ptr];
  assign out_last  = out_valid && (sent_cnt == CW'(DEPTH - 1));
  assign pop       = out_valid && out_ready;
  assign last_hs   = pop && (sent_cnt == CW'(DEPTH - 1));

  // Words that will occupy the FIFO once this cycle's pop and the pending
  // read return are accounted for; a new read is only safe if that leaves
  // room for its data next cycle.
  assign level = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign issue = (state == STREAM) && (issue_cnt < CW'(DEPTH)) && (level <= 3'd1);

  assign mem_read_enable = issue;
  assign mem_address     = issue_cnt[ADDR_WIDTH-1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      issue_cnt   <= '0;
      sent_cnt    <= '0;
      inflight    <= 1'b0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
    end else begin
      done     <= 1'b0;
      inflight <= issue;
      count    <= count + {1'b0, inflight} - {1'b0, pop};

      if (inflight) begin
        fifo_mem[wr_ptr] <= mem_read_data;
        wr_ptr           <= ~wr_ptr;
      end

      if (pop) begin
        rd_ptr   <= ~rd_ptr;
        sent_cnt <= sent_cnt + 1'b1;
      end

      if (issue) begin
        issue_cnt <= issue_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state     <= STREAM;
            busy      <= 1'b1;
            issue_cnt <= '0;
            sent_cnt  <= '0;
          end
        end
        STREAM: begin
          if (last_hs) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_occupancy_map_dumper.sv
// Bench for occupancy_map_dumper: reduced DEPTH, a registered RAM model and
// a behavioural reference checked against the DUT every cycle.
module tb_occupancy_map_dumper;

  localparam int DW    = 8;
  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam int BOUND = DEPTH * 8 + 100;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          busy;
  logic          done;
  logic          mem_read_enable;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_read_data = '0;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;

  occupancy_map_dumper #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .busy            (busy),
    .done            (done),
    .mem_read_enable (mem_read_enable),
    .mem_address     (mem_address),
    .mem_read_data   (mem_read_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_last        (out_last)
  );

  always #5 clock = ~clock;

  logic [DW-1:0] ram [DEPTH];
  always @(posedge clock) begin
    if (mem_read_enable) mem_read_data <= ram[mem_address];
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a dump is a single pass over addresses 0..DEPTH-1;
  // words leave in order, reads stay at most two ahead of accepted words.
  bit            m_active   = 0;
  bit            m_done_exp = 0;
  int            m_issued   = 0;
  int            m_sent     = 0;
  bit            prev_stall = 0;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  int            start_cyc  = 0;
  int            first_cyc  = -1;
  int            done_cyc   = 0;
  int            done_pulses = 0;
  logic [DW-1:0] last_val   = '0;

  always @(negedge clock) begin
    bit hs;
    bit done_next;
    if (reset) begin
      m_active   = 0;
      m_done_exp = 0;
      m_issued   = 0;
      m_sent     = 0;
      prev_stall = 0;
    end else begin
      chk("busy", busy, m_active);
      chk("done", done, m_done_exp);
      if (done) begin
        done_pulses++;
        done_cyc = cyc;
      end
      hs = out_valid && out_ready;
      if (!m_active) begin
        chk("idle_rd_en", mem_read_enable, 0);
        chk("idle_valid", out_valid, 0);
      end
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_data);
        chk("stall_last", out_last, prev_last);
      end
      if (out_valid && m_sent < DEPTH) begin
        chk("data", out_data, ram[m_sent]);
        chk("last", out_last, (m_sent == DEPTH - 1));
        if (first_cyc < 0) first_cyc = cyc;
        if (out_last) last_val = out_data;
      end else begin
        chk("last_idle", out_last, 0);
      end
      if (hs) m_sent++;
      if (mem_read_enable) begin
        chk("rd_addr", mem_address, m_issued % DEPTH);
        chk("rd_in_range", (m_issued < DEPTH), 1);
        m_issued++;
        chk("outstanding", (m_issued - m_sent <= 2), 1);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      done_next = m_active && hs && (m_sent == DEPTH);
      if (done_next) begin
        m_active = 0;
      end else if (!m_active && !m_done_exp && start) begin
        m_active  = 1;
        m_issued  = 0;
        m_sent    = 0;
        start_cyc = cyc;
        first_cyc = -1;
      end
      m_done_exp = done_next;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // mode 0: ready held high; mode 1: ready random 50%.
  task automatic run_dump(input int mode, input int stall, input int restart_at,
                          input int reset_at);
    int d0;
    int k;
    bit pulsed;
    d0 = done_pulses;
    pulsed = 0;
    k = 0;
    out_ready = (mode == 0) && (stall == 0);
    start = 1'b1;
    step(1);
    start = 1'b0;
    if (stall > 0) begin
      step(stall);
      chk("stall_reads", m_issued, 2);
      chk("stall_hold_valid", out_valid, 1);
      chk("stall_hold_data", out_data, ram[0]);
      chk("stall_no_read", mem_read_enable, 0);
    end
    while (done_pulses == d0 && k < BOUND) begin
      out_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      start = 1'b0;
      if (restart_at >= 0 && !pulsed && m_sent >= restart_at) begin
        start = 1'b1;
        pulsed = 1;
      end
      if (reset_at >= 0 && m_sent >= reset_at) begin
        chk("valid_before_reset", out_valid, 1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("valid_after_reset", out_valid, 0);
        chk("busy_after_reset", busy, 0);
        step(2);
        return;
      end
      step(1);
      k++;
    end
    start = 1'b0;
    chk("dump_timeout", (k < BOUND), 1);
    step(3);
    chk("single_done", done_pulses - d0, 1);
    chk("busy_after_done", busy, 0);
    chk("words_sent", m_sent, DEPTH);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) ram[i] = DW'(i);
    step(3);
    reset = 1'b0;
    step(10);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", mem_read_enable, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);

    run_dump(0, 0, -1, -1);
    chk("first_word_latency", first_cyc - start_cyc, 3);
    chk("done_cycle", done_cyc - start_cyc, 259);
    chk("last_word_value", last_val, 8'hFF);

    run_dump(1, 0, -1, -1);
    run_dump(0, 100, -1, -1);

    for (int i = 0; i < DEPTH; i++) ram[i] = DW'($urandom);
    run_dump(1, 0, 100, -1);
    run_dump(1, 0, -1, -1);

    run_dump(0, 0, -1, 200);
    run_dump(1, 0, -1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
